cache_mem_bridge: RTL

- Sits directly downstream of the cache, between its block load/store requests and the word-wide synchronous RAM.
- Replaces the level-sensitive wait handshakes with a clocked valid/ready request port and a one-cycle response pulse.
- Posts cache-block stores into a write buffer and drains them to RAM in the background.
- Serves block loads from RAM with a configurable wait-state count.

---
 rtl/cache_mem_bridge_if.sv | 36 +++
 rtl/cache_mem_bridge.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/cache_mem_bridge_if.sv
// Request/response and RAM-side signal bundle for cache_mem_bridge.
//
// Handshake: the request port is strict valid/ready. A request transfers on
// a rising clk edge where req_valid && req_ready are both high; the cache
// holds req_write/req_addr/req_wdata stable while req_valid is high and not
// yet accepted. resp_valid is a one-cycle pulse with no backpressure, and
// resp_rdata holds its value until the next response. mem_rdata is expected
// one cycle after the RAM samples mem_addr.
interface cache_mem_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_rdata;

  // Bridge side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_wren
  );

  // Cache + RAM environment side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: posts cache block stores into a write buffer that drains
// to a word-wide synchronous RAM in the background, and serves block loads
// from RAM with WAIT_CYCLES stall cycles before every RAM access.
// Optional feature macro CACHE_MEM_BRIDGE_FWD_EN: loads are looked up in the
// write buffer (youngest match wins) and a miss goes to RAM ahead of the
// buffered stores. Without it, loads wait until the buffer is empty.
module cache_mem_bridge #(
  parameter int BUF_DEPTH   = 4,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  cache_mem_bridge_if.slave            bus,
  output logic [$clog2(BUF_DEPTH):0]   buf_count,
  output logic                         busy,
  output logic [2:0]                   dbg_state
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  // Loaded on state entry; the state is left once the counter reads zero,
  // which gives exactly WAIT_CYCLES cycles in a wait state.
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_WAIT  = 3'd1,
    D_WR    = 3'd2,
    R_WAIT  = 3'd3,
    R_ISSUE = 3'd4,
    R_CAP   = 3'd5
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;

  logic [ADDR_W-1:0] buf_addr [BUF_DEPTH];
  logic [DATA_W-1:0] buf_data [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              full;
  logic              push;
  logic              pop;
  logic              load_ok;
  logic              load_acc;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [ADDR_W-1:0] req_word;
  logic              unused_addr_bits;

  // Byte address to RAM word index; the two low bits carry no information.
  assign req_word         = {2'b00, bus.req_addr[ADDR_W-1:2]};
  assign unused_addr_bits = ^bus.req_addr[1:0];

  assign full = (buf_count == (PTR_W+1)'(BUF_DEPTH));
  assign push = bus.req_valid && bus.req_write && !full;
  assign pop  = (state == D_WR);

`ifdef CACHE_MEM_BRIDGE_FWD_EN
  assign load_ok = (state == IDLE);

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (((PTR_W+1)'(i) < buf_count) && (buf_addr[rd_ptr + PTR_W'(i)] == req_word)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data[rd_ptr + PTR_W'(i)];
      end
    end
  end
`else
  assign load_ok  = (state == IDLE) && (buf_count == '0);
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  assign bus.req_ready = bus.req_write ? !full : load_ok;
  assign load_acc      = bus.req_valid && !bus.req_write && load_ok;

  assign busy      = (state != IDLE) || (buf_count != '0);
  assign dbg_state = state;

  // Write-buffer storage: written on every accepted store, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[wr_ptr] <= req_word;
      buf_data[wr_ptr] <= bus.req_wdata;
    end
  end

  // Write-buffer pointers and occupancy; a push and pop together cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   buf_count <= buf_count + 1'b1;
        2'b01:   buf_count <= buf_count - 1'b1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  // Main FSM with registered RAM and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_wren   <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.mem_wren   <= 1'b0;
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load_acc) begin
            if (fwd_hit) begin
              bus.resp_rdata <= fwd_data;
              bus.resp_valid <= 1'b1;
            end else begin
              bus.mem_addr <= req_word;
              wait_cnt     <= CNT_RELOAD;
              if (WAIT_CYCLES == 0) state <= R_ISSUE;
              else                  state <= R_WAIT;
            end
          end else if (buf_count != '0) begin
            bus.mem_addr  <= buf_addr[rd_ptr];
            bus.mem_wdata <= buf_data[rd_ptr];
            wait_cnt      <= CNT_RELOAD;
            if (WAIT_CYCLES == 0) begin
              state        <= D_WR;
              bus.mem_wren <= 1'b1;
            end else begin
              state <= D_WAIT;
            end
          end
        end
        D_WAIT: begin
          if (wait_cnt == '0) begin
            state        <= D_WR;
            bus.mem_wren <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        D_WR: begin
          state <= IDLE;
        end
        R_WAIT: begin
          if (wait_cnt == '0) state <= R_ISSUE;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        R_ISSUE: begin
          state <= R_CAP;
        end
        R_CAP: begin
          bus.resp_rdata <= bus.mem_rdata;
          bus.resp_valid <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
